// File: rtl/music_sequencer.sv
// Frame-synchronous 16-step note sequencer: plays a small pattern RAM, one step every
// FRAMES_PER_STEP video frames, with a gated, decaying volume envelope per note.
module music_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned GATE_FRAMES     = 6,
    parameter bit          LOOP            = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       cfg_we_i,
    input  logic [3:0] cfg_addr_i,
    input  logic [5:0] cfg_data_i,
    output logic [9:0] tone_period_o,
    output logic       tone_load_o,
    output logic       gate_o,
    output logic [3:0] volume_o,
    output logic [3:0] step_o,
    output logic       busy_o,
    output logic       loop_done_o
);

    typedef enum logic [1:0] {StIdle, StGateOn, StGateOff} state_e;

    localparam logic [5:0] LastFrame = 6'(FRAMES_PER_STEP - 1);
    localparam logic [5:0] LastGate  = 6'(GATE_FRAMES - 1);

    state_e      state_q, state_d;
    logic        busy_q;
    logic [5:0]  ram_q [16];
    logic        v_sync_q;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  step_q, step_d;
    logic [9:0]  tone_period_q, tone_period_d;
    logic        tone_load_q, tone_load_d;
    logic        gate_q, gate_d;
    logic [3:0]  volume_q, volume_d;
    logic        loop_done_q, loop_done_d;

    logic        tick;
    logic        playing;
    logic        step_end;
    logic        gate_end;
    logic        wrap_stop;
    logic        do_load;
    logic [3:0]  load_step;
    logic [5:0]  load_code;

    // Rising edge of v_sync marks one frame.
    assign tick      = v_sync_i & ~v_sync_q;
    assign playing   = (state_q != StIdle);
    assign step_end  = tick & playing & (frame_cnt_q == LastFrame);
    assign gate_end  = tick & (state_q == StGateOn) & (frame_cnt_q == LastGate);
    assign wrap_stop = step_end & (step_q == 4'd15) & ~LOOP;
    assign load_step = start_i ? 4'd0 : step_q + 4'd1;
    assign do_load   = ~stop_i & (start_i | (step_end & ~wrap_stop));
    assign load_code = ram_q[load_step];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                ram_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            ram_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    // State register; busy is registered alongside so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_i || (!start_i && wrap_stop)) begin
            state_d = StIdle;
        end else if (do_load) begin
            state_d = (load_code != 6'd0) ? StGateOn : StGateOff;
        end else if (gate_end) begin
            state_d = StGateOff;
        end
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        step_d        = step_q;
        tone_period_d = tone_period_q;
        tone_load_d   = 1'b0;
        gate_d        = gate_q;
        volume_d      = volume_q;
        loop_done_d   = 1'b0;

        if (stop_i) begin
            frame_cnt_d   = '0;
            step_d        = '0;
            tone_period_d = '0;
            gate_d        = 1'b0;
            volume_d      = '0;
        end else if (start_i) begin
            step_d = 4'd0;
        end else if (tick && playing) begin
            frame_cnt_d = frame_cnt_q + 6'd1;
            if (step_end) begin
                loop_done_d = (step_q == 4'd15);
                step_d      = step_q + 4'd1;
                if (wrap_stop) begin
                    frame_cnt_d   = '0;
                    tone_period_d = '0;
                    gate_d        = 1'b0;
                    volume_d      = '0;
                end
            end else if (state_q == StGateOn) begin
                if (frame_cnt_q == LastGate) begin
                    gate_d   = 1'b0;
                    volume_d = '0;
                end else if (frame_cnt_q < LastGate) begin
                    volume_d = (volume_q > 4'd8) ? volume_q - 4'd1 : 4'd8;
                end
            end
        end

        // Step load overrides the per-tick envelope update above.
        if (do_load) begin
            frame_cnt_d   = '0;
            tone_period_d = {load_code, 4'b0000};
            tone_load_d   = 1'b1;
            gate_d        = (load_code != 6'd0);
            volume_d      = (load_code != 6'd0) ? 4'd15 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q      <= 1'b0;
            frame_cnt_q   <= '0;
            step_q        <= '0;
            tone_period_q <= '0;
            tone_load_q   <= 1'b0;
            gate_q        <= 1'b0;
            volume_q      <= '0;
            loop_done_q   <= 1'b0;
        end else begin
            v_sync_q      <= v_sync_i;
            frame_cnt_q   <= frame_cnt_d;
            step_q        <= step_d;
            tone_period_q <= tone_period_d;
            tone_load_q   <= tone_load_d;
            gate_q        <= gate_d;
            volume_q      <= volume_d;
            loop_done_q   <= loop_done_d;
        end
    end

    assign tone_period_o = tone_period_q;
    assign tone_load_o   = tone_load_q;
    assign gate_o        = gate_q;
    assign volume_o      = volume_q;
    assign step_o        = step_q;
    assign busy_o        = busy_q;
    assign loop_done_o   = loop_done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: directed vector table, multi-cycle corner sequences, and a
// randomized run against a frame-counting reference model.
module tb_music_sequencer;

    localparam int FPS = 8;
    localparam int GF  = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_sync = 1'b0, start = 1'b0, stop = 1'b0, cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [5:0] cfg_data = '0;

    logic [9:0] tp1, tp2;
    logic       tl1, tl2, g1, g2, bsy1, bsy2, ld1, ld2;
    logic [3:0] vol1, vol2, stp1, stp2;

    int checks = 0;
    int failures = 0;
    int ld1_cnt, ld2_cnt, tl2_cnt;

    always #5 clk = ~clk;

    music_sequencer #(.FRAMES_PER_STEP(FPS), .GATE_FRAMES(GF), .LOOP(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .v_sync_i(v_sync), .start_i(start), .stop_i(stop),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
        .tone_period_o(tp1), .tone_load_o(tl1), .gate_o(g1), .volume_o(vol1),
        .step_o(stp1), .busy_o(bsy1), .loop_done_o(ld1)
    );

    music_sequencer #(.FRAMES_PER_STEP(2), .GATE_FRAMES(1), .LOOP(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .v_sync_i(v_sync), .start_i(start), .stop_i(stop),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
        .tone_period_o(tp2), .tone_load_o(tl2), .gate_o(g2), .volume_o(vol2),
        .step_o(stp2), .busy_o(bsy2), .loop_done_o(ld2)
    );

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [5:0] data;
        logic       st, sp, vs;
        int         tp, tl, g, vol, stp, bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic we, input int addr, input int data, input logic st,
                           input logic sp, input logic vs, input int tp, input int tl,
                           input int g, input int vol, input int stp, input int bsy);
        vec_t v;
        v.we = we; v.addr = 4'(addr); v.data = 6'(data);
        v.st = st; v.sp = sp; v.vs = vs;
        v.tp = tp; v.tl = tl; v.g = g; v.vol = vol; v.stp = stp; v.bsy = bsy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after each rising edge and outputs sampled there too.
    task automatic step_cyc();
        @(posedge clk);
        #1;
        ld1_cnt += int'(ld1);
        ld2_cnt += int'(ld2);
        tl2_cnt += int'(tl2);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            v_sync = 1'b1; step_cyc();
            v_sync = 1'b0; step_cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; step_cyc(); start = 1'b0;
    endtask

    task automatic write_ram(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = 6'(data);
        step_cyc();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        v_sync = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        rst_n = 1'b0;
        step_cyc(); step_cyc();
        rst_n = 1'b1;
    endtask

    // Reference model: playback described as "frames since the current step was loaded".
    bit m_play, m_tl, m_ld, m_vprev;
    int m_step, m_f, m_code;
    int m_ram[16];

    task automatic model_reset();
        m_play = 0; m_tl = 0; m_ld = 0; m_vprev = 0;
        m_step = 0; m_f = 0; m_code = 0;
        for (int i = 0; i < 16; i++) m_ram[i] = 0;
    endtask

    task automatic model_load();
        m_play = 1; m_code = m_ram[m_step]; m_f = 0; m_tl = 1;
    endtask

    task automatic model_edge();
        bit tk;
        tk = v_sync && !m_vprev;
        m_vprev = v_sync;
        m_tl = 0; m_ld = 0;
        if (stop) begin
            m_play = 0; m_step = 0; m_f = 0; m_code = 0;
        end else if (start) begin
            m_step = 0; model_load();
        end else if (tk && m_play) begin
            if (m_f == FPS - 1) begin
                if (m_step == 15) m_ld = 1;
                m_step = (m_step + 1) % 16;
                model_load();
            end else begin
                m_f++;
            end
        end
        if (cfg_we) m_ram[cfg_addr] = int'(cfg_data);
    endtask

    task automatic model_compare(input int cyc);
        int eg, ev;
        eg = (m_play && m_code != 0 && m_f < GF) ? 1 : 0;
        ev = eg ? ((15 - m_f < 8) ? 8 : 15 - m_f) : 0;
        chk($sformatf("rnd%0d_tp", cyc), int'(tp1), m_play ? m_code * 16 : 0);
        chk($sformatf("rnd%0d_tl", cyc), int'(tl1), int'(m_tl));
        chk($sformatf("rnd%0d_gate", cyc), int'(g1), eg);
        chk($sformatf("rnd%0d_vol", cyc), int'(vol1), ev);
        chk($sformatf("rnd%0d_step", cyc), int'(stp1), m_step);
        chk($sformatf("rnd%0d_busy", cyc), int'(bsy1), int'(m_play));
        chk($sformatf("rnd%0d_loopdone", cyc), int'(ld1), int'(m_ld));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ld1_cnt = 0; ld2_cnt = 0; tl2_cnt = 0;

        // we addr data st sp vs | tp tl g vol step busy
        add_vec(1, 0, 5, 0, 0, 0,   0, 0, 0,  0, 0, 0);
        add_vec(1, 1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
        add_vec(0, 0, 0, 1, 0, 0,  80, 1, 1, 15, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 1, 14, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 1, 14, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 1, 13, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 1, 13, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 1, 12, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 1, 12, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 1, 11, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 1, 11, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 1, 10, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 1, 10, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 0,  0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 0,  0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 0,  0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 0,  0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,   0, 1, 0,  0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 1, 1);
        add_vec(0, 0, 0, 1, 0, 0,  80, 1, 1, 15, 0, 1);
        add_vec(0, 0, 0, 0, 1, 1,   0, 0, 0,  0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
        add_vec(0, 0, 0, 1, 0, 1,  80, 1, 1, 15, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0,  80, 0, 1, 15, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,  80, 0, 1, 14, 0, 1);
        add_vec(0, 0, 0, 0, 1, 0,   0, 0, 0,  0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 1,   0, 0, 0,  0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_data = tbl[i].data;
            start = tbl[i].st; stop = tbl[i].sp; v_sync = tbl[i].vs;
            step_cyc();
            chk($sformatf("vec%0d_tp", i), int'(tp1), tbl[i].tp);
            chk($sformatf("vec%0d_tl", i), int'(tl1), tbl[i].tl);
            chk($sformatf("vec%0d_gate", i), int'(g1), tbl[i].g);
            chk($sformatf("vec%0d_vol", i), int'(vol1), tbl[i].vol);
            chk($sformatf("vec%0d_step", i), int'(stp1), tbl[i].stp);
            chk($sformatf("vec%0d_busy", i), int'(bsy1), tbl[i].bsy);
        end
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0; v_sync = 1'b0;

        // Rewriting the playing step only takes effect on its next visit.
        write_ram(3, 2);
        pulse_start();
        ld1_cnt = 0;
        do_ticks(24);
        chk("edit_step_before", int'(stp1), 3);
        chk("edit_tp_before", int'(tp1), 32);
        write_ram(3, 9);
        chk("edit_tp_after_write", int'(tp1), 32);
        do_ticks(3);
        chk("edit_tp_same_visit", int'(tp1), 32);
        do_ticks(125);
        chk("edit_step_revisit", int'(stp1), 3);
        chk("edit_tp_revisit", int'(tp1), 144);
        chk("edit_gate_revisit", int'(g1), 1);
        chk("edit_loop_done_count", ld1_cnt, 1);
        stop = 1'b1; step_cyc(); stop = 1'b0;

        // Asynchronous reset in the middle of a gated note.
        pulse_start();
        do_ticks(2);
        chk("arst_pre_vol", int'(vol1), 13);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tp", int'(tp1), 0);
        chk("arst_gate", int'(g1), 0);
        chk("arst_vol", int'(vol1), 0);
        chk("arst_busy", int'(bsy1), 0);
        chk("arst_step", int'(stp1), 0);
        chk("arst_tl", int'(tl1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step_cyc();
        do_ticks(10);
        chk("arst_ticks_busy", int'(bsy1), 0);
        chk("arst_ticks_tp", int'(tp1), 0);
        chk("arst_ticks_gate", int'(g1), 0);
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("readback%0d_step", k), int'(stp1), k);
            chk($sformatf("readback%0d_tp", k), int'(tp1), 0);
            chk($sformatf("readback%0d_gate", k), int'(g1), 0);
            do_ticks(8);
        end
        stop = 1'b1; step_cyc(); stop = 1'b0;

        // Play-once instance with two frames per step.
        do_reset();
        write_ram(0, 5);
        pulse_start();
        chk("once_start_tp", int'(tp2), 80);
        chk("once_start_busy", int'(bsy2), 1);
        ld2_cnt = 0; tl2_cnt = 0;
        do_ticks(32);
        chk("once_loop_done_count", ld2_cnt, 1);
        chk("once_tone_loads", tl2_cnt, 15);
        chk("once_end_busy", int'(bsy2), 0);
        chk("once_end_step", int'(stp2), 0);
        chk("once_end_tp", int'(tp2), 0);
        tl2_cnt = 0;
        do_ticks(6);
        chk("once_idle_tone_loads", tl2_cnt, 0);
        chk("once_idle_busy", int'(bsy2), 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            start    = ($urandom_range(0, 63) == 0);
            stop     = ($urandom_range(0, 199) == 0);
            v_sync   = 1'($urandom_range(0, 1));
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_data = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            model_edge();
            step_cyc();
            model_compare(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter: FRAMES_PER_STEP, default 8, number of frame ticks per sequencer step (legal 2..63).
REQ-002 Parameter: GATE_FRAMES, default 6, number of frame ticks the gate is held per non-rest step (legal 1..FRAMES_PER_STEP-1).
REQ-003 Parameter: LOOP, default 1; 1 means the pattern repeats, 0 means play once and stop.
REQ-004 Port: clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: v_sync  input  1  frame sync level from the VGA controller.
REQ-007 Port: start  input  1  one-cycle pulse that begins playback at step 0.
REQ-008 Port: stop  input  1  one-cycle pulse that aborts playback.
REQ-009 Port: cfg_we / cfg_addr / cfg_data  input  1/4/6  pattern RAM write port; cfg_data is a note code, where 0 means rest.
REQ-010 Port: tone_period  output  10  half-period for the audio engine, equal to note_code << 4.
REQ-011 Port: tone_load  output  1  one-cycle pulse, asserted when tone_period changes on a step load.
REQ-012 Port: gate  output  1  note-on indication.
REQ-013 Port: volume  output  4  envelope level.
REQ-014 Port: step  output  4  current step index.
REQ-015 Port: busy  output  1  high in any state other than IDLE.
REQ-016 Port: loop_done  output  1  one-cycle pulse on a 15->0 step wrap.

Function
REQ-017 Pattern RAM: 16 x 6 flops; a write with cfg_we=1 updates the entry on the clock edge, in any state.
REQ-018 A write to the currently playing step does not change the outputs until that step is next loaded.
REQ-019 Frame tick: v_sync is registered into v_sync_q; tick = v_sync & ~v_sync_q, one cycle wide, once per frame.
REQ-020 FSM states: IDLE, GATE_ON, GATE_OFF.
REQ-021 Step load (registered, visible the cycle after the triggering edge):
- tone_period = ram[step] << 4;
- tone_load = 1 for one cycle;
- frame_cnt = 0;
- if the code is nonzero: gate = 1, volume = 15, state GATE_ON;
- if the code is zero: gate = 0, volume = 0, state GATE_OFF.
REQ-022 IDLE + start: step = 0, then step load.
REQ-023 Every tick in GATE_ON or GATE_OFF increments frame_cnt (6 bits).
REQ-024 GATE_ON + tick with frame_cnt < GATE_FRAMES-1: volume decrements by 1 and saturates at 8.
REQ-025 GATE_ON + tick with frame_cnt == GATE_FRAMES-1: gate = 0, volume = 0, state GATE_OFF; gate is therefore high for exactly GATE_FRAMES ticks.
REQ-026 Tick with frame_cnt == FRAMES_PER_STEP-1: step = step+1 (mod 16), then step load.
REQ-027 If step was 15 when it advances: loop_done = 1 for one cycle.
REQ-028 On the 15->0 wrap with LOOP = 0: no step load; instead state IDLE, gate = 0, volume = 0, tone_period = 0, step = 0.
REQ-029 Stop in any state: next state IDLE, gate = 0, volume = 0, tone_period = 0, step = 0, no tone_load.
REQ-030 Event priority: stop > start > tick.
- start while busy restarts at step 0 with a fresh step load.
- start and tick in the same cycle: the tick is ignored.
REQ-031 Ticks in IDLE are ignored, and the outputs hold their reset values.
REQ-032 tone_load, loop_done and tick are never asserted for two consecutive cycles.
REQ-033 busy equals (state != IDLE), registered together with the state.

Reset
REQ-034 Asserting rst_n = 0 at any time, including mid-step, forces the following immediately, without waiting for clk:
- state IDLE;
- all 16 RAM entries = 0;
- tone_period = 0, tone_load = 0, gate = 0, volume = 0, step = 0, busy = 0, loop_done = 0;
- frame_cnt = 0, v_sync_q = 0.
REQ-035 After release, the block stays in IDLE until the first start that is sampled while rst_n = 1.

Verification
REQ-036 Setup: write ram[0] = 5 and ram[1] = 0, then pulse start. Required response on the next cycle:
- tone_period = 80, tone_load = 1 for one cycle;
- gate = 1, volume = 15, busy = 1, step = 0.
REQ-037 Defaults, 6 ticks after REQ-036: volume sequence 15, 14, 13, 12, 11, 10, then gate = 0 and volume = 0 at the 6th tick. At the 8th tick: step = 1, tone_load pulses, tone_period = 0, gate remains 0 (rest step).
REQ-038 LOOP = 0, FRAMES_PER_STEP = 2: after start and 32 ticks, required:
- loop_done pulses once;
- then busy = 0, step = 0, tone_period = 0, and no further tone_load.
REQ-039 stop and tick in the same cycle during GATE_ON → IDLE with gate = 0 and no step advance. start and tick in the same cycle in IDLE → step 0 loads and frame_cnt = 0.
REQ-040 During step 3, write ram[3] = 9: tone_period is unchanged until the next visit to step 3, where it is 144.
REQ-041 Assert rst_n = 0 mid-GATE_ON, asynchronously between clock edges: all outputs go to 0 immediately. After release, ticks alone cause no activity, and a readback by playing all steps gives rests only.
